// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// hazard event codes and the priority used to arbitrate between them.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_LU_STALL = 2'd3
  } ctrl_state_t;

  // A larger rank wins when several hazard events are raised in the same cycle.
  localparam int PRIO_LOAD_USE = 0;
  localparam int PRIO_JUMP     = 1;
  localparam int PRIO_BRANCH   = 2;
  localparam int PRIO_MEM      = 3;
  localparam int PRIO_LEVELS   = 4;

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LOAD_USE = 3'(PRIO_LOAD_USE + 1),
    EV_JUMP     = 3'(PRIO_JUMP + 1),
    EV_BRANCH   = 3'(PRIO_BRANCH + 1),
    EV_MEM      = 3'(PRIO_MEM + 1)
  } hazard_event_t;

  function automatic hazard_event_t select_event(input logic mem_wait,
                                                 input logic branch,
                                                 input logic jump,
                                                 input logic load_use);
    logic [PRIO_LEVELS-1:0] req;
    hazard_event_t          sel;
    req                = '0;
    req[PRIO_MEM]      = mem_wait;
    req[PRIO_BRANCH]   = branch;
    req[PRIO_JUMP]     = jump;
    req[PRIO_LOAD_USE] = load_use;
    sel = EV_NONE;
    // Ascending scan: the highest-ranked active request is the one left standing.
    for (int i = 0; i < PRIO_LEVELS; i++) begin
      if (req[i]) sel = hazard_event_t'(3'(i + 1));
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load
// in EX has yet to write. Register 0 is hard-wired and never creates a hazard.
module hazard_detect (
  input  logic       EX_MemRead,
  input  logic [4:0] EX_rt,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  output logic       load_use
);

  logic [1:0] src_match;
  logic [4:0] id_src [2];

  assign id_src[0] = ID_rs;
  assign id_src[1] = ID_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign src_match[gi] = (id_src[gi] == EX_rt);
    end
  endgenerate

  assign load_use = EX_MemRead && (EX_rt != 5'd0) && (|src_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory waits, taken branches, jumps and
// load-use hazards into stall/flush controls, with a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rt,
  input  logic             EX_BranchTaken,
  input  logic             ID_Jump,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_hold,
  output logic             MEMWB_bubble,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_t      state_reg, state_next;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0] stall_cycles_reg;
  logic             load_use;
  hazard_event_t    event_sel;

  hazard_detect u_hazard_detect (
    .EX_MemRead (EX_MemRead),
    .EX_rt      (EX_rt),
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .load_use   (load_use)
  );

  assign event_sel = select_event(MEM_req && !MEM_ready, EX_BranchTaken,
                                  ID_Jump, load_use);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_RUN;
      wait_cnt_reg     <= 8'd0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (!PC_write && (stall_cycles_reg != '1)) begin
        stall_cycles_reg <= stall_cycles_reg + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    PC_write      = 1'b1;
    IFID_write    = 1'b1;
    IFID_flush    = 1'b0;
    IDEX_flush    = 1'b0;
    EXMEM_hold    = 1'b0;
    MEMWB_bubble  = 1'b0;
    mem_timeout   = 1'b0;

    case (state_reg)
      ST_RUN: begin
        case (event_sel)
          EV_MEM: begin
            PC_write      = 1'b0;
            IFID_write    = 1'b0;
            EXMEM_hold    = 1'b1;
            MEMWB_bubble  = 1'b1;
            state_next    = ST_MEM_WAIT;
            wait_cnt_next = 8'd0;
          end
          EV_BRANCH: begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            state_next = ST_REDIRECT;
          end
          EV_JUMP: begin
            IFID_flush = 1'b1;
          end
          EV_LOAD_USE: begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
            state_next = ST_LU_STALL;
          end
          default: ;
        endcase
      end
      ST_MEM_WAIT: begin
        if (MEM_ready) begin
          state_next = ST_RUN;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // Give up on the access: let the pipe move but keep WB from committing.
          mem_timeout  = 1'b1;
          MEMWB_bubble = 1'b1;
          state_next   = ST_RUN;
        end else begin
          PC_write      = 1'b0;
          IFID_write    = 1'b0;
          EXMEM_hold    = 1'b1;
          MEMWB_bubble  = 1'b1;
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      ST_REDIRECT: begin
        // Whatever is in EX now is on the squashed path, so its branch is ignored.
        state_next = ST_RUN;
      end
      ST_LU_STALL: begin
        if (event_sel == EV_MEM) begin
          PC_write      = 1'b0;
          IFID_write    = 1'b0;
          EXMEM_hold    = 1'b1;
          MEMWB_bubble  = 1'b1;
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = 8'd0;
        end else begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase

    // While reset is held the controls present the idle RUN values.
    if (!reset) begin
      PC_write     = 1'b1;
      IFID_write   = 1'b1;
      IFID_flush   = 1'b0;
      IDEX_flush   = 1'b0;
      EXMEM_hold   = 1'b0;
      MEMWB_bubble = 1'b0;
      mem_timeout  = 1'b0;
    end
  end

  assign state_o      = state_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max MEM_WAIT cycles before abort (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16: width of stall statistics counter.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports ID_rs, ID_rt  in  5 each  source register numbers of instruction in ID.
REQ-006 SHALL have ports EX_MemRead  in  1, EX_rt  in  5  load in EX and its destination register.
REQ-007 SHALL have port EX_BranchTaken  in  1  branch resolved taken in EX.
REQ-008 SHALL have port ID_Jump  in  1  jump decoded in ID.
REQ-009 SHALL have ports MEM_req  in  1, MEM_ready  in  1  data-memory access in MEM stage and its completion.
REQ-010 SHALL have ports PC_write, IFID_write  out  1 each  enable PC / IF-ID update.
REQ-011 SHALL have ports IFID_flush, IDEX_flush  out  1 each  load bubble into IF-ID / ID-EX.
REQ-012 SHALL have port EXMEM_hold  out  1  freeze EX-MEM register.
REQ-013 SHALL have port MEMWB_bubble  out  1  force RegWr=0, MemtoReg=0 into MEM-WB.
REQ-014 SHALL have ports mem_timeout  out  1  one-cycle abort pulse; state_o  out  2  current state.
REQ-015 SHALL have port stall_cycles  out  CNT_W  saturating count of cycles with PC_write=0.

Function
REQ-016 SHALL implement states RUN(0), MEM_WAIT(1), REDIRECT(2), LU_STALL(3); state_o equals encoding.
REQ-017 SHALL drive all control outputs combinationally from state and current inputs (zero-cycle latency); state, wait counter and stall_cycles registered.
REQ-018 Load-use hazard SHALL be EX_MemRead=1 and EX_rt!=0 and (EX_rt==ID_rs or EX_rt==ID_rt).
REQ-019 Event priority SHALL be: MEM wait > EX_BranchTaken > ID_Jump > load-use.
REQ-020 RUN, MEM_req=1 and MEM_ready=0: PC_write=IFID_write=0, EXMEM_hold=1, MEMWB_bubble=1, no flushes; next MEM_WAIT, counter cleared to 0.
REQ-021 MEM_WAIT: same outputs as REQ-020 while MEM_ready=0; counter increments per cycle; MEM_ready=1 releases pipe that cycle (all holds off, MEMWB_bubble=0), next RUN.
REQ-022 MEM_WAIT with counter==MEM_TIMEOUT-1 and MEM_ready=0: mem_timeout=1, MEMWB_bubble=1, holds released, next RUN.
REQ-023 RUN, EX_BranchTaken=1 (no MEM wait): IFID_flush=IDEX_flush=1, PC_write=1; next REDIRECT.
REQ-024 REDIRECT: no flush or stall, one cycle, next RUN; exists so a second taken branch in the following cycle is ignored (squashed path).
REQ-025 RUN, ID_Jump=1, no higher event: IFID_flush=1 only; stays RUN.
REQ-026 RUN, load-use, no higher event: PC_write=IFID_write=0, IDEX_flush=1; next LU_STALL.
REQ-027 LU_STALL: all outputs inactive regardless of hazard inputs (one stall maximum), next RUN; MEM wait in this state takes REQ-020 path.
REQ-028 Inactive defaults SHALL be PC_write=IFID_write=1, all others 0.
REQ-029 stall_cycles SHALL increment when PC_write=0 and saturate at all-ones.

Reset
REQ-030 reset low SHALL asynchronously force state RUN, wait counter 0, stall_cycles 0; outputs then take RUN defaults (PC_write=IFID_write=1, others 0, state_o=0).
REQ-031 Reset asserted mid MEM_WAIT or LU_STALL SHALL abandon the stall with no mem_timeout pulse.

Structure
REQ-032 State encodings and event-priority constants SHALL reside in shared package pipe_ctrl_pkg.
REQ-033 Load-use comparator SHALL be sub-module hazard_detect (pure combinational); FSM, counters in top.

Verification
REQ-034 EX lw rt=5, ID rs=5 -> PC_write=0, IDEX_flush=1 for 1 cycle, state_o 3 then 0, stall_cycles=1.
REQ-035 EX lw rt=0, ID rs=0 -> no stall, outputs at defaults.
REQ-036 MEM_req=1, MEM_ready low 3 cycles then high -> EXMEM_hold=1 for 3 cycles, release on 4th, stall_cycles=3.
REQ-037 MEM_req=1, MEM_ready never, MEM_TIMEOUT=4 -> mem_timeout pulse on 4th wait cycle, state_o back to 0.
REQ-038 EX_BranchTaken=1 with same-cycle load-use -> IFID_flush=IDEX_flush=1, PC_write=1; second EX_BranchTaken next cycle ignored.
REQ-039 reset low during MEM_WAIT -> state_o=0, stall_cycles=0, mem_timeout=0 immediately.
